// File: rtl/call_request_latch.sv
// call_request_latch: synchronise/debounce hall+cab calls, latch pending
// requests, present unissued ones over valid/ack. Option: CALL_LATCH_DEBOUNCE_EN.
module call_request_latch #(
  parameter int DEBOUNCE_MAX = 250000,
  parameter int CNT_W        = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hall_raw,
  input  logic [3:0] cab_raw,
  input  logic [1:0] actual_floor,
  input  logic       stopped,
  output logic [5:0] hall_pending,
  output logic [3:0] cab_pending,
  output logic       req_valid,
  output logic [1:0] req_floor,
  output logic       req_dir,
  output logic       req_is_cab,
  input  logic       req_ack
);

  // Channels 0..3 are cab floors, 4..9 are hall switches; index is priority.
  localparam int NCH = 10;

  logic [NCH-1:0] w_raw;
  logic [NCH-1:0] r_s1;
  logic [NCH-1:0] r_s2;
  logic [NCH-1:0] r_deb;
  logic [NCH-1:0] r_pend;
  logic [NCH-1:0] r_iss;
  logic [NCH-1:0] w_press;
  logic [NCH-1:0] w_clr;
  logic [NCH-1:0] w_ack_set;
  logic [NCH-1:0] w_avail;
  logic [3:0]     w_cand;
  logic           w_cand_ok;
  logic [1:0]     w_floor;
  logic           w_dir;
  logic           w_cab;
  logic           r_valid;
  logic [3:0]     r_sel;
  logic [1:0]     r_floor;
  logic           r_dir;
  logic           r_cab;

  assign w_raw = {hall_raw, cab_raw};

  // Out-of-range configuration leaves a visible marker in the hierarchy.
  if (DEBOUNCE_MAX < 1 || CNT_W < 1) begin : g_bad_cfg
  end

  // Two-flop synchroniser per channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
    end
  end

`ifdef CALL_LATCH_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_MAX - 1);

  logic [CNT_W-1:0] r_cnt [NCH];
  logic [NCH-1:0]   w_flip;

  // A level flips once it has disagreed for DEBOUNCE_MAX cycles.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NCH; i++) begin
      w_flip[i] = (r_s2[i] != r_deb[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_press = w_flip & r_s2;

  // Per-channel run counter and debounced level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_cnt[i] <= '0;
          r_deb[i] <= r_s2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  assign w_press = r_s2 & ~r_deb;

  // Inputs are clean already; the level just tracks the synchroniser.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_deb <= '0;
    end else begin
      r_deb <= r_s2;
    end
  end
`endif

  // Service clear: cab bit plus both hall bits of the stopped floor.
  always_comb begin
    w_clr = '0;
    if (stopped) begin
      w_clr[{2'b00, actual_floor}] = 1'b1;
      case (actual_floor)
        2'd0:    w_clr[4]   = 1'b1;
        2'd1:    w_clr[6:5] = 2'b11;
        2'd2:    w_clr[8:7] = 2'b11;
        default: w_clr[9]   = 1'b1;
      endcase
    end
  end

  // Issued flag for the channel accepted this cycle.
  always_comb begin
    w_ack_set = '0;
    if (r_valid && req_ack) begin
      w_ack_set[r_sel] = 1'b1;
    end
  end

  assign w_avail = r_pend & ~r_iss & ~w_clr;

  // Lowest-index available channel wins.
  always_comb begin
    w_cand    = '0;
    w_cand_ok = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_avail[i]) begin
        w_cand    = 4'(i);
        w_cand_ok = 1'b1;
      end
    end
  end

  // Channel to (floor, dir, is_cab).
  always_comb begin
    w_floor = '0;
    w_dir   = 1'b0;
    w_cab   = 1'b0;
    if (w_cand_ok) begin
      case (w_cand)
        4'd0, 4'd1, 4'd2, 4'd3: begin
          w_floor = w_cand[1:0];
          w_cab   = 1'b1;
        end
        4'd4: w_floor = 2'd0;
        4'd5: w_floor = 2'd1;
        4'd6: begin
          w_floor = 2'd1;
          w_dir   = 1'b1;
        end
        4'd7: w_floor = 2'd2;
        4'd8: begin
          w_floor = 2'd2;
          w_dir   = 1'b1;
        end
        default: begin
          w_floor = 2'd3;
          w_dir   = 1'b1;
        end
      endcase
    end
  end

  // Pending and issued latches; service clear beats press and ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_iss  <= '0;
    end else begin
      r_pend <= (r_pend | w_press) & ~w_clr;
      r_iss  <= (r_iss | w_ack_set) & ~w_clr;
    end
  end

  // Presentation: hold until ack or withdrawal, idle one cycle after ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_floor <= '0;
      r_dir   <= 1'b0;
      r_cab   <= 1'b0;
    end else if (r_valid && (req_ack || w_clr[r_sel])) begin
      r_valid <= 1'b0;
      r_sel   <= '0;
      r_floor <= '0;
      r_dir   <= 1'b0;
      r_cab   <= 1'b0;
    end else if (!r_valid) begin
      r_valid <= w_cand_ok;
      r_sel   <= w_cand;
      r_floor <= w_floor;
      r_dir   <= w_dir;
      r_cab   <= w_cab;
    end
  end

  assign hall_pending = r_pend[9:4];
  assign cab_pending  = r_pend[3:0];
  assign req_valid    = r_valid;
  assign req_floor    = r_floor;
  assign req_dir      = r_dir;
  assign req_is_cab   = r_cab;

endmodule
